// File: rtl/cmd_pkt_responder.sv
// Responder end of the remote-command link: 8N1 UART receiver/transmitter
// plus a 3-byte command packet assembler with inter-byte timeout.
module cmd_pkt_responder #(
   parameter int unsigned BAUD_DIV = 2604,
   parameter int unsigned TIMEOUT  = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy,
   output logic        frm_err
);

   localparam int unsigned BW = $clog2(BAUD_DIV + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

   localparam logic [1:0] WAIT_CMD = 2'd0;
   localparam logic [1:0] WAIT_HI  = 2'd1;
   localparam logic [1:0] WAIT_LO  = 2'd2;

   logic          rx_s1, rx_s2, rx_d;
   logic          rx_busy;
   logic [BW-1:0] rx_cnt;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic [7:0]    rx_byte;
   logic          byte_vld;
   logic          start_det_c;

   logic [TW-1:0] to_cnt;
   logic          to_hit_c;

   logic [1:0]    state_q, state_d;
   logic          store_cmd_c, store_hi_c, complete_c;
   logic [7:0]    cmd_sh, hi_sh;

   logic [9:0]    tx_sh;
   logic [BW-1:0] tx_cnt;
   logic [3:0]    tx_bits;

   // Two-flop synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d  <= 1'b1;
      end else begin
         rx_s1 <= RX;
         rx_s2 <= rx_s1;
         rx_d  <= rx_s2;
      end
   end

   assign start_det_c = ~rx_busy & rx_d & ~rx_s2;

   // Bit-level receiver: index 0 = start, 1..8 = data LSB first, 9 = stop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_busy  <= 1'b0;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_byte  <= '0;
         byte_vld <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         byte_vld <= 1'b0;
         frm_err  <= 1'b0;
         if (start_det_c) begin
            rx_busy <= 1'b1;
            rx_cnt  <= BAUD_HALF;
            rx_bit  <= '0;
         end else if (rx_busy) begin
            if (rx_cnt != '0) begin
               rx_cnt <= rx_cnt - BW'(1);
            end else begin
               rx_cnt <= BAUD_LAST;
               rx_bit <= rx_bit + 4'd1;
               if (rx_bit == 4'd0) begin
                  if (rx_s2) rx_busy <= 1'b0;
               end else if (rx_bit == 4'd9) begin
                  rx_busy <= 1'b0;
                  if (rx_s2) begin
                     byte_vld <= 1'b1;
                     rx_byte  <= rx_sh;
                  end else begin
                     frm_err <= 1'b1;
                  end
               end else begin
                  rx_sh <= {rx_s2, rx_sh[7:1]};
               end
            end
         end
      end
   end

   // Inter-byte timeout: counts idle cycles inside a partial packet, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state_q == WAIT_CMD || start_det_c) begin
         to_cnt <= '0;
      end else if (!rx_busy && to_cnt != TO_LIMIT) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   assign to_hit_c = (to_cnt == TO_LIMIT);

   // Packet FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= WAIT_CMD;
      else     state_q <= state_d;
   end

   // Packet FSM next state and byte-store strobes
   always_comb begin
      state_d     = state_q;
      store_cmd_c = 1'b0;
      store_hi_c  = 1'b0;
      complete_c  = 1'b0;
      if (frm_err) begin
         state_d = WAIT_CMD;
      end else if (byte_vld) begin
         case (state_q)
            WAIT_CMD: begin store_cmd_c = 1'b1; state_d = WAIT_HI;  end
            WAIT_HI:  begin store_hi_c  = 1'b1; state_d = WAIT_LO;  end
            WAIT_LO:  begin complete_c  = 1'b1; state_d = WAIT_CMD; end
            default:  state_d = WAIT_CMD;
         endcase
      end else if (state_q != WAIT_CMD && to_hit_c) begin
         state_d = WAIT_CMD;
      end
   end

   // Shadow bytes and the packet outputs; set of cmd_rdy wins over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_sh  <= '0;
         hi_sh   <= '0;
         cmd     <= '0;
         data    <= '0;
         cmd_rdy <= 1'b0;
      end else begin
         if (store_cmd_c) cmd_sh <= rx_byte;
         if (store_hi_c)  hi_sh  <= rx_byte;
         if (complete_c) begin
            cmd  <= cmd_sh;
            data <= {hi_sh, rx_byte};
         end
         if (complete_c)                      cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || store_cmd_c) cmd_rdy <= 1'b0;
      end
   end

   // Response transmitter: 10-bit frame shifted LSB first, BAUD_DIV cycles per bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         TX        <= 1'b1;
         tx_sh     <= '1;
         tx_cnt    <= '0;
         tx_bits   <= '0;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else if (!tx_busy) begin
         if (send_resp) begin
            tx_sh     <= {1'b1, resp, 1'b0};
            TX        <= 1'b0;
            tx_cnt    <= BAUD_LAST;
            tx_bits   <= '0;
            tx_busy   <= 1'b1;
            resp_sent <= 1'b0;
         end
      end else if (tx_cnt != '0) begin
         tx_cnt <= tx_cnt - BW'(1);
      end else if (tx_bits == 4'd9) begin
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b1;
      end else begin
         tx_sh   <= {1'b1, tx_sh[9:1]};
         TX      <= tx_sh[1];
         tx_bits <= tx_bits + 4'd1;
         tx_cnt  <= BAUD_LAST;
      end
   end

endmodule

// File: tb/tb_cmd_pkt_responder.sv
// Bench for cmd_pkt_responder: UART initiator model, packet/response
// scoreboards and independent RX/TX monitors.
module tb_cmd_pkt_responder;

   localparam int BD = 32;
   localparam int TO = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        tx_busy;
   logic        frm_err;

   cmd_pkt_responder #(.BAUD_DIV(BD), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
      .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
      .send_resp(send_resp), .resp_sent(resp_sent), .tx_busy(tx_busy),
      .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [23:0] exp_q[$];
   logic [7:0]  exp_tx_q[$];
   logic [7:0]  m_bytes[3];
   int          m_n = 0;
   int          exp_frm = 0;
   int          tx_last_acc = -100000;

   // monitor observations
   int frm_seen = 0;
   int n_rise = 0;
   int rise_edge = 0;
   int last_fall = 0;
   bit rx_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_reset();
      m_n = 0;
      exp_q.delete();
      exp_tx_q.delete();
      tx_last_acc = -100000;
   endtask

   // Packet rules: 3 good bytes make a packet; a framing error or a long gap drops the partial one
   task automatic model_byte(input logic [7:0] b, input bit bad);
      if (bad) begin
         m_n = 0;
         exp_frm++;
      end else begin
         m_bytes[m_n] = b;
         m_n++;
         if (m_n == 3) begin
            exp_q.push_back({m_bytes[0], m_bytes[1], m_bytes[2]});
            m_n = 0;
         end
      end
   endtask

   // Initiator: one 8N1 byte; caller is aligned 1 time unit after a clock edge
   task automatic uart_byte(input logic [7:0] b, input bit bad_stop);
      logic [9:0] fr;
      fr = {~bad_stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = fr[i];
         if (i == 0) last_fall = cyc;
         if (i == 9) model_byte(b, bad_stop);
         repeat (BD) @(posedge clk);
         #1;
      end
      RX = 1'b1;
   endtask

   task automatic idle(input int n);
      RX = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      if (n > TO) m_n = 0;
   endtask

   // Response request; accepted only when the previous frame ended at least one cycle earlier
   task automatic tx_send(input logic [7:0] r, output int e);
      resp = r;
      send_resp = 1'b1;
      e = cyc + 1;
      if (e >= tx_last_acc + 10*BD + 1) begin
         exp_tx_q.push_back(r);
         tx_last_acc = e;
      end
      @(posedge clk);
      #1;
      send_resp = 1'b0;
   endtask

   task automatic wait_tx_idle();
      for (int i = 0; i < 12*BD && tx_busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("tx_idle_wait", 32'(tx_busy), 32'd0);
   endtask

   // Packet monitor: compare cmd/data on each cmd_rdy rise; they must not move otherwise
   initial begin
      logic        prev_rdy;
      logic [23:0] prev_cd, cur, e;
      prev_rdy = 1'b0;
      prev_cd  = '0;
      forever begin
         @(posedge clk);
         #1;
         cur = {cmd, data};
         if (rst) begin
            prev_rdy = 1'b0;
            prev_cd  = '0;
         end else begin
            if (frm_err) frm_seen++;
            if (cmd_rdy && !prev_rdy) begin
               rise_edge = cyc;
               n_rise++;
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL pkt_unexpected: cmd=0x%0h data=0x%0h, required no packet", cmd, data);
               end else begin
                  e = exp_q.pop_front();
                  check("pkt_cmd", 32'(cmd), 32'(e[23:16]));
                  check("pkt_data", 32'(data), 32'(e[15:0]));
               end
            end else if (cur !== prev_cd) begin
               check("pkt_regs_stable", 32'(cur), 32'(prev_cd));
            end
            prev_rdy = cmd_rdy;
            prev_cd  = cur;
         end
      end
   end

   // TX monitor: every frame must match the next accepted response bit-for-bit and cycle-for-cycle
   initial begin
      logic [7:0] r, dec;
      logic [9:0] bits;
      int         mism;
      bit         aborted;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && TX === 1'b0) begin
            if (exp_tx_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_unexpected_frame: TX low at cycle %0d, required idle", cyc);
               repeat (10*BD) @(posedge clk);
               #1;
            end else begin
               r = exp_tx_q.pop_front();
               bits = {1'b1, r, 1'b0};
               dec = '0;
               aborted = 0;
               for (int b = 0; b < 10 && !aborted; b++) begin
                  mism = 0;
                  for (int s = 0; s < BD; s++) begin
                     if (b != 0 || s != 0) begin
                        @(posedge clk);
                        #1;
                     end
                     if (rst) begin
                        aborted = 1;
                        break;
                     end
                     if (TX !== bits[b]) mism++;
                     if (b >= 1 && b <= 8 && s == BD/2) dec[b-1] = TX;
                     if (b == 9 && s == BD-1) begin
                        check("tx_busy_in_stop", 32'(tx_busy), 32'd1);
                        check("tx_sent_in_stop", 32'(resp_sent), 32'd0);
                     end
                  end
                  if (!aborted) check("tx_bit_bad_samples", 32'(mism), 32'd0);
               end
               if (!aborted) begin
                  @(posedge clk);
                  #1;
                  if (!rst) begin
                     check("tx_byte", 32'(dec), 32'(r));
                     check("tx_done_busy", 32'(tx_busy), 32'd0);
                     check("tx_done_sent", 32'(resp_sent), 32'd1);
                  end
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e0, rises;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_TX", 32'(TX), 32'd1);
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("rst_resp_sent", 32'(resp_sent), 32'd0);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_frm_err", 32'(frm_err), 32'd0);
      rst = 1'b0;
      idle(5);

      // basic packet and latency
      uart_byte(8'h05, 0);
      uart_byte(8'hAB, 0);
      uart_byte(8'hCD, 0);
      check_range("rdy_latency", rise_edge - last_fall, 9*BD + BD/2, 9*BD + BD/2 + 6);
      idle(10);
      check("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
      check("t1_cmd", 32'(cmd), 32'h05);
      check("t1_data", 32'(data), 32'hABCD);
      check("t1_no_frm_err", 32'(frm_seen), 32'd0);

      // back-to-back packets, no idle, no clear
      uart_byte(8'h01, 0);
      uart_byte(8'h12, 0);
      uart_byte(8'h34, 0);
      check("t2_rdy_after_pkt1", 32'(cmd_rdy), 32'd1);
      uart_byte(8'h02, 0);
      check("t2_rdy_after_byte0", 32'(cmd_rdy), 32'd0);
      uart_byte(8'h56, 0);
      uart_byte(8'h78, 0);
      check("t2_rdy_after_pkt2", 32'(cmd_rdy), 32'd1);
      check("t2_cmd", 32'(cmd), 32'h02);
      check("t2_data", 32'(data), 32'h5678);

      // timeout discards the partial packet
      idle(5);
      uart_byte(8'h03, 0);
      uart_byte(8'h11, 0);
      idle(2500);
      uart_byte(8'h04, 0);
      uart_byte(8'h22, 0);
      uart_byte(8'h33, 0);
      idle(5);
      check("t3_cmd", 32'(cmd), 32'h04);
      check("t3_data", 32'(data), 32'h2233);

      // framing error mid-packet
      uart_byte(8'h09, 0);
      uart_byte(8'h5A, 1);
      idle(40);
      check("t4_frm_count", 32'(frm_seen), 32'(exp_frm));
      uart_byte(8'h06, 0);
      uart_byte(8'h00, 0);
      uart_byte(8'h01, 0);
      idle(5);
      check("t4_cmd", 32'(cmd), 32'h06);
      check("t4_data", 32'(data), 32'h0001);

      // clear pulse, then completion while clear is held (set wins)
      clr_cmd_rdy = 1'b1;
      @(posedge clk);
      #1;
      clr_cmd_rdy = 1'b0;
      check("t5_clr", 32'(cmd_rdy), 32'd0);
      rises = n_rise;
      clr_cmd_rdy = 1'b1;
      uart_byte(8'h0A, 0);
      uart_byte(8'hBE, 0);
      uart_byte(8'hEF, 0);
      idle(3);
      clr_cmd_rdy = 1'b0;
      check("t5_set_wins_rise", 32'(n_rise - rises), 32'd1);
      check("t5_rdy_cleared", 32'(cmd_rdy), 32'd0);
      check("t5_cmd", 32'(cmd), 32'h0A);

      // response frame, busy rejection, end-of-frame boundary
      wait_tx_idle();
      tx_send(8'hA5, e0);
      repeat (100) @(posedge clk);
      #1;
      tx_send(8'h3C, e);
      for (int i = 0; i < 400 && cyc < e0 + 319; i++) begin
         @(posedge clk);
         #1;
      end
      check("t6_busy_before_end", 32'(tx_busy), 32'd1);
      check("t6_sent_before_end", 32'(resp_sent), 32'd0);
      tx_send(8'h11, e);
      check("t6_sent_at_end", 32'(resp_sent), 32'd1);
      check("t6_busy_at_end", 32'(tx_busy), 32'd0);
      tx_send(8'h77, e);
      check("t6_resend_busy", 32'(tx_busy), 32'd1);
      check("t6_resend_clears_sent", 32'(resp_sent), 32'd0);
      wait_tx_idle();

      // reset mid-byte and mid-frame
      idle(5);
      uart_byte(8'h0B, 0);
      tx_send(8'hC3, e);
      RX = 1'b0;
      repeat (BD + BD/2) @(posedge clk);
      #1;
      check("t7_busy_pre_rst", 32'(tx_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t7_TX", 32'(TX), 32'd1);
      check("t7_cmd", 32'(cmd), 32'd0);
      check("t7_data", 32'(data), 32'd0);
      check("t7_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("t7_tx_busy", 32'(tx_busy), 32'd0);
      check("t7_resp_sent", 32'(resp_sent), 32'd0);
      check("t7_frm_err", 32'(frm_err), 32'd0);
      model_reset();
      RX = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(20);
      uart_byte(8'h07, 0);
      uart_byte(8'hFF, 0);
      uart_byte(8'hFE, 0);
      idle(5);
      check("t7_cmd_after", 32'(cmd), 32'h07);
      check("t7_data_after", 32'(data), 32'hFFFE);

      // randomized full-duplex traffic
      fork
         begin
            for (int p = 0; p < 8; p++) begin
               for (int j = 0; j < 3; j++) begin
                  if ($urandom_range(0, 9) == 0) begin
                     uart_byte(8'($urandom), 1);
                     idle(40);
                  end
                  uart_byte(8'($urandom), 0);
                  idle(int'($urandom_range(0, 20)));
               end
            end
            rx_done = 1;
         end
         begin
            int et;
            for (int k = 0; k < 10; k++) begin
               repeat ($urandom_range(50, 700)) @(posedge clk);
               #1;
               tx_send(8'($urandom), et);
            end
         end
         begin
            while (!rx_done) begin
               repeat ($urandom_range(100, 800)) @(posedge clk);
               #1;
               clr_cmd_rdy = 1'b1;
               @(posedge clk);
               #1;
               clr_cmd_rdy = 1'b0;
            end
         end
      join
      wait_tx_idle();
      idle(50);
      check("end_pkt_queue_empty", 32'(exp_q.size()), 32'd0);
      check("end_tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
      check("end_frm_count", 32'(frm_seen), 32'(exp_frm));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cmd_pkt_responder.md
# cmd_pkt_responder

Responder end of the remote-command link: a self-contained 8N1 UART plus packet engine that receives 3-byte command packets (cmd, data high, data low) from the remote initiator and returns 1-byte responses. It sits between the serial pins and the command-configuration logic, exposing a parallel cmd/data/ready handshake on one side and a resp/send handshake on the other.

## Interface
- BAUD_DIV, 2604: clock cycles per bit (50 MHz / 19200 baud); legal range 8..65535.
- TIMEOUT, 1_000_000: idle cycles allowed between bytes of one packet before the partial packet is discarded.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial input from initiator, idle high, asynchronous to clk.
- TX  out  1  serial output to initiator, idle high.
- cmd  out  8  opcode of the last complete packet.
- data  out  16  payload of the last complete packet, {byte1, byte2}.
- cmd_rdy  out  1  level; high when a complete packet is held.
- clr_cmd_rdy  in  1  one-cycle pulse; clears cmd_rdy.
- resp  in  8  response byte; sampled when send_resp is high.
- send_resp  in  1  one-cycle pulse; starts a response transmission.
- resp_sent  out  1  level; set when the response stop bit completes.
- tx_busy  out  1  high while a response is shifting out.
- frm_err  out  1  one-cycle pulse on a bad stop bit.

## Operation
- RX path: 2-flop synchronizer, both flops preset to 1 on reset. A falling edge while the receiver is idle starts a byte. The receiver samples at BAUD_DIV/2 (start bit), then every BAUD_DIV cycles for 8 data bits (LSB first) and the stop bit.
  - Start bit sampled high: false start; return to idle with no byte.
  - Stop bit sampled low: frm_err pulses, the byte is dropped, and the packet FSM returns to WAIT_CMD.
- Packet FSM states: WAIT_CMD -> WAIT_HI -> WAIT_LO -> WAIT_CMD, advancing on each good byte.
  - Bytes are stored in shadow registers.
  - On the WAIT_LO byte, cmd and data update together in one cycle and cmd_rdy sets.
  - cmd and data never change except at packet completion.
- Timeout: in WAIT_HI or WAIT_LO, a counter runs while no byte is in progress. Reaching TIMEOUT returns the FSM to WAIT_CMD with the partial packet discarded. The counter resets on every start-bit detection.
- cmd_rdy:
  - Cleared by clr_cmd_rdy, or when byte 0 of the next packet completes.
  - Packet completion in the same cycle as clr_cmd_rdy leaves cmd_rdy set (set wins).
- TX path:
  - Idle: send_resp loads {1, resp, 0} into a 10-bit shifter, sets tx_busy and clears resp_sent.
  - Busy: send_resp is ignored.
  - Each bit is held BAUD_DIV cycles. After the stop bit, tx_busy clears and resp_sent sets.
- RX and TX are independent; full-duplex operation is legal.

## Timing
- Reset values:
  - Outputs: TX=1, cmd=0, data=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0.
  - Internal: FSM = WAIT_CMD, all counters 0.
- Reset asserted mid-byte or mid-packet aborts everything immediately; no partial output update.
- RX latency: cmd_rdy rises 1 cycle after the stop-bit sample of byte 2. That sample is at 9.5×BAUD_DIV (+2 synchronizer cycles) after byte 2's falling edge.
- Receiver is idle again after the stop-bit sample, so back-to-back bytes with zero idle time are accepted.
- TX latency: TX goes low the cycle after send_resp. Each bit lasts exactly BAUD_DIV cycles. tx_busy falls and resp_sent rises together, 10×BAUD_DIV cycles after TX first went low.
- A send_resp in the same cycle tx_busy falls is ignored; the earliest accepted send_resp is 1 cycle later.
- Counter widths: baud counter $clog2(BAUD_DIV+1) bits, timeout counter $clog2(TIMEOUT+1) bits; neither wraps (both saturate/reload).

## Test plan
- BAUD_DIV=32, TIMEOUT=2000. Initiator model sends 0x05, 0xAB, 0xCD -> cmd_rdy rises within 2 cycles of the byte-2 stop sample; cmd=0x05, data=0xABCD; frm_err never pulses.
- Two back-to-back packets (0x01,0x12,0x34 then 0x02,0x56,0x78) with no idle time and no clr_cmd_rdy:
  - After the first packet: cmd_rdy=1.
  - After byte 0 of the second packet: cmd_rdy=0.
  - After the second packet: cmd_rdy=1 again, with data=0x5678 and cmd=0x02.
- Send 0x03, 0x11, then idle 2500 cycles, then 0x04, 0x22, 0x33 -> partial packet discarded; result cmd=0x04, data=0x2233.
- Byte with stop bit forced low mid-packet -> frm_err pulses once, FSM restarts. A following full packet 0x06,0x00,0x01 yields cmd=0x06, data=0x0001.
- send_resp with resp=0xA5:
  - Line: TX shows 0,1,0,1,0,0,1,0,1,1, each held 32 cycles.
  - Flags: resp_sent=1 at cycle 321.
  - Busy rejection: a second send_resp mid-frame does not disturb the frame.
- rst asserted during byte 1 of a packet and during a TX frame -> TX=1 immediately, all outputs at reset values. A subsequent packet 0x07,0xFF,0xFE is received correctly.
